// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
// ------------------
// Machine-mode trap / MRET sequencer. Captures one event at a time from the
// pipeline (exception, MRET or an eligible interrupt), writes mepc, mcause,
// mbadaddr and mstatus over a fixed sequence of cycles, then offers a
// redirect PC to fetch with a valid/ready handshake. The mip mirror runs
// continuously and is independent of the sequence.
//
// Ports
//   CLK, RST                     clock; synchronous active-high reset
//   exc_valid/code/epc/badaddr   exception report (held until exc_ack)
//   exc_badaddr_valid            exc_badaddr is meaningful
//   mret_valid                   MRET committed (held until exc_ack)
//   exc_ack                      one-cycle pulse when an event is captured
//   int_epc                      PC saved when an interrupt is taken
//   ext_int/soft_int/timer_int   level interrupt sources
//   mip/mie/mstatus/mtvec/mepc   CSR read-back values
//   *_rup / *_next               CSR write strobes and write data
//   busy                         sequencer not idle; fetch stalls
//   redirect_valid/pc/ready      redirect handshake towards fetch
module prv_trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_epc,
  input  logic [XLEN-1:0] exc_badaddr,
  input  logic            exc_badaddr_valid,
  input  logic            mret_valid,
  output logic            exc_ack,
  input  logic [XLEN-1:0] int_epc,
  input  logic            ext_int,
  input  logic            soft_int,
  input  logic            timer_int,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            mip_rup,
  output logic            mepc_rup,
  output logic            mcause_rup,
  output logic            mbadaddr_rup,
  output logic            mstatus_rup,
  output logic [XLEN-1:0] mip_next,
  output logic [XLEN-1:0] mepc_next,
  output logic [XLEN-1:0] mcause_next,
  output logic [XLEN-1:0] mbadaddr_next,
  output logic [XLEN-1:0] mstatus_next,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    STATUS,
    RET,
    REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;
  logic            bad_valid_q, bad_valid_d;
  logic [XLEN-1:0] target_q, target_d;

  // Interrupt eligibility; the fixed order below gives ext > soft > timer.
  logic       int_ext, int_soft, int_timer, int_any;
  logic [4:0] int_code;
  logic [XLEN-1:0] mip_mirror;

  assign int_ext   = mstatus[3] & mie[11] & ext_int;
  assign int_soft  = mstatus[3] & mie[3]  & soft_int;
  assign int_timer = mstatus[3] & mie[7]  & timer_int;
  assign int_any   = int_ext | int_soft | int_timer;
  assign int_code  = int_ext ? 5'd11 : (int_soft ? 5'd3 : 5'd7);

  always_comb begin
    mip_mirror     = mip;
    mip_mirror[11] = ext_int;
    mip_mirror[3]  = soft_int;
    mip_mirror[7]  = timer_int;
  end

  // While RST is high the mirror is silenced along with every other strobe.
  assign mip_rup  = !RST && (mip_mirror != mip);
  assign mip_next = mip_rup ? mip_mirror : '0;

  assign busy           = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = target_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    badaddr_d     = badaddr_q;
    bad_valid_d   = bad_valid_q;
    target_d      = target_q;
    exc_ack       = 1'b0;
    mepc_rup      = 1'b0;
    mcause_rup    = 1'b0;
    mbadaddr_rup  = 1'b0;
    mstatus_rup   = 1'b0;
    mepc_next     = '0;
    mcause_next   = '0;
    mbadaddr_next = '0;
    mstatus_next  = '0;

    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          exc_ack     = 1'b1;
          cause_d     = {28'b0, exc_code};
          epc_d       = exc_epc;
          bad_valid_d = exc_badaddr_valid;
          badaddr_d   = exc_badaddr_valid ? exc_badaddr : '0;
          state_d     = SAVE;
        end else if (mret_valid) begin
          exc_ack = 1'b1;
          state_d = RET;
        end else if (int_any) begin
          exc_ack     = 1'b1;
          cause_d     = {1'b1, 26'b0, int_code};
          epc_d       = int_epc;
          bad_valid_d = 1'b0;
          badaddr_d   = '0;
          state_d     = SAVE;
        end
      end
      SAVE: begin
        mepc_rup    = 1'b1;
        mepc_next   = {epc_q[XLEN-1:2], 2'b00};
        mcause_rup  = 1'b1;
        mcause_next = cause_q;
        if (bad_valid_q) begin
          mbadaddr_rup  = 1'b1;
          mbadaddr_next = badaddr_q;
        end
        state_d = STATUS;
      end
      STATUS: begin
        // Trap entry: MPIE <= MIE, MIE <= 0.
        mstatus_rup     = 1'b1;
        mstatus_next    = mstatus;
        mstatus_next[7] = mstatus[3];
        mstatus_next[3] = 1'b0;
        target_d        = {mtvec[XLEN-1:2], 2'b00};
        state_d         = REDIRECT;
      end
      RET: begin
        // Trap return: MIE <= MPIE, MPIE <= 1.
        mstatus_rup     = 1'b1;
        mstatus_next    = mstatus;
        mstatus_next[3] = mstatus[7];
        mstatus_next[7] = 1'b1;
        target_d        = mepc;
        state_d         = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle aborts the sequence: nothing may reach the CSR file.
    if (RST) begin
      exc_ack       = 1'b0;
      mepc_rup      = 1'b0;
      mcause_rup    = 1'b0;
      mbadaddr_rup  = 1'b0;
      mstatus_rup   = 1'b0;
      mepc_next     = '0;
      mcause_next   = '0;
      mbadaddr_next = '0;
      mstatus_next  = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      epc_q       <= '0;
      badaddr_q   <= '0;
      bad_valid_q <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badaddr_q   <= badaddr_d;
      bad_valid_q <= bad_valid_d;
      target_q    <= target_d;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb_prv_trap_sequencer
// Directed test-plan steps followed by randomized events. Inputs change one
// time unit after the rising edge; outputs are sampled on the falling edge.
// Expected behaviour comes from an event-level model: pick the event from the
// priority rules, then derive the per-cycle CSR writes and redirect target.
module tb_prv_trap_sequencer;

  logic        CLK, RST;
  logic        exc_valid, exc_badaddr_valid, mret_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_epc, exc_badaddr, int_epc;
  logic        ext_int, soft_int, timer_int;
  logic [31:0] mip, mie, mstatus, mtvec, mepc;
  logic        exc_ack;
  logic        mip_rup, mepc_rup, mcause_rup, mbadaddr_rup, mstatus_rup;
  logic [31:0] mip_next, mepc_next, mcause_next, mbadaddr_next, mstatus_next;
  logic        busy, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  int vectors     = 0;
  int miscompares = 0;

  prv_trap_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badaddr(exc_badaddr), .exc_badaddr_valid(exc_badaddr_valid),
    .mret_valid(mret_valid), .exc_ack(exc_ack), .int_epc(int_epc),
    .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
    .mip(mip), .mie(mie), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
    .mip_rup(mip_rup), .mepc_rup(mepc_rup), .mcause_rup(mcause_rup),
    .mbadaddr_rup(mbadaddr_rup), .mstatus_rup(mstatus_rup),
    .mip_next(mip_next), .mepc_next(mepc_next), .mcause_next(mcause_next),
    .mbadaddr_next(mbadaddr_next), .mstatus_next(mstatus_next),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_code = 0; exc_epc = 0; exc_badaddr = 0;
    exc_badaddr_valid = 0; mret_valid = 0; int_epc = 0;
    ext_int = 0; soft_int = 0; timer_int = 0;
    mip = 0; mie = 0; mstatus = 0; mtvec = 0; mepc = 0;
    redirect_ready = 0;
  endtask

  task automatic check_mip(input string tag);
    logic [31:0] m;
    m = (mip & ~32'h0000_0888) | ({31'b0, ext_int} << 11) |
        ({31'b0, soft_int} << 3) | ({31'b0, timer_int} << 7);
    check({tag, ".mip_rup"}, {31'b0, mip_rup}, {31'b0, m != mip});
    if (m != mip) check({tag, ".mip_next"}, mip_next, m);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".strobes"}, {28'b0, mepc_rup, mcause_rup, mbadaddr_rup, mstatus_rup}, 32'h0);
  endtask

  // Applies the currently driven inputs from IDLE and follows the whole event.
  // Events and interrupts are held while busy and dropped on the ready cycle.
  task automatic run_event(input string tag, input int delay);
    int          kind;
    int          bits[3];
    logic        pend[3];
    logic [31:0] cause, epc, bad, target, ms_exp;
    logic        badv;
    kind = 0; cause = 0; epc = 0; bad = 0; badv = 0; target = 0; ms_exp = 0;
    bits[0] = 11; bits[1] = 3; bits[2] = 7;
    pend[0] = ext_int; pend[1] = soft_int; pend[2] = timer_int;
    if (exc_valid) begin
      kind = 1; cause = {28'b0, exc_code}; epc = exc_epc;
      badv = exc_badaddr_valid; bad = exc_badaddr;
    end else if (mret_valid) begin
      kind = 2;
    end else begin
      for (int i = 0; i < 3; i++)
        if (kind == 0 && mstatus[3] && mie[bits[i]] && pend[i]) begin
          kind = 3; cause = 32'h8000_0000 + bits[i]; epc = int_epc;
        end
    end

    @(negedge CLK);
    check({tag, ".ack"}, {31'b0, exc_ack}, {31'b0, kind != 0});
    check({tag, ".idle_busy"}, {31'b0, busy}, 32'h0);
    check_mip(tag);
    if (kind == 0) begin
      tick();
      @(negedge CLK);
      check({tag, ".still_idle"}, {31'b0, busy}, 32'h0);
      tick();
      return;
    end

    tick();
    @(negedge CLK);
    check({tag, ".held_no_ack"}, {31'b0, exc_ack}, 32'h0);
    check({tag, ".busy"}, {31'b0, busy}, 32'h1);
    if (kind == 2) begin
      ms_exp = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
      target = mepc;
      check({tag, ".ret.rups"}, {28'b0, mepc_rup, mcause_rup, mbadaddr_rup, mstatus_rup}, 32'h1);
      check({tag, ".ret.mstatus"}, mstatus_next, ms_exp);
    end else begin
      check({tag, ".save.rups"}, {28'b0, mepc_rup, mcause_rup, mbadaddr_rup, mstatus_rup},
            {28'b0, 1'b1, 1'b1, badv, 1'b0});
      check({tag, ".save.mepc"}, mepc_next, epc & ~32'h3);
      check({tag, ".save.mcause"}, mcause_next, cause);
      if (badv) check({tag, ".save.mbadaddr"}, mbadaddr_next, bad);
      check({tag, ".save.no_redirect"}, {31'b0, redirect_valid}, 32'h0);
      tick();
      @(negedge CLK);
      ms_exp = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
      target = mtvec & ~32'h3;
      check({tag, ".status.rups"}, {28'b0, mepc_rup, mcause_rup, mbadaddr_rup, mstatus_rup}, 32'h1);
      check({tag, ".status.mstatus"}, mstatus_next, ms_exp);
      check({tag, ".status.no_ack"}, {31'b0, exc_ack}, 32'h0);
    end

    for (int i = 0; i <= delay; i++) begin
      tick();
      redirect_ready = (i == delay);
      if (i == delay) begin
        exc_valid = 0; mret_valid = 0; ext_int = 0; soft_int = 0; timer_int = 0;
      end
      @(negedge CLK);
      check($sformatf("%s.redir%0d.valid", tag, i), {31'b0, redirect_valid}, 32'h1);
      check($sformatf("%s.redir%0d.pc", tag, i), redirect_pc, target);
      check($sformatf("%s.redir%0d.busy", tag, i), {31'b0, busy}, 32'h1);
      check_quiet($sformatf("%s.redir%0d", tag, i));
    end
    tick();
    redirect_ready = 0;
    @(negedge CLK);
    check({tag, ".back_idle"}, {30'b0, busy, redirect_valid}, 32'h0);
    tick();
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    tick(); tick();
    @(negedge CLK);
    check("reset.ctl", {29'b0, exc_ack, busy, redirect_valid}, 32'h0);
    check("reset.pc", redirect_pc, 32'h0);
    check_quiet("reset");
    check("reset.mip_rup", {31'b0, mip_rup}, 32'h0);
    tick();
    RST = 0;
    tick();

    // Exception with a valid bad address.
    exc_valid = 1; exc_code = 4'd2; exc_epc = 32'h100; exc_badaddr = 32'h55;
    exc_badaddr_valid = 1; mtvec = 32'h200; mstatus = 32'h8;
    run_event("exc", 0);

    // Timer interrupt, then the same with MIE clear (must be ignored).
    clear_inputs();
    mie = 32'h80; mstatus = 32'h8; int_epc = 32'h40; mtvec = 32'h200;
    timer_int = 1; mip = 32'h80;
    run_event("timer", 1);
    timer_int = 1; mstatus = 32'h0;
    run_event("timer_masked", 0);

    // Exception wins over pending interrupts; then ext beats timer.
    clear_inputs();
    mie = 32'h880; mstatus = 32'h8; mtvec = 32'h304; int_epc = 32'h1002;
    exc_valid = 1; exc_code = 4'd5; exc_epc = 32'h77; ext_int = 1; timer_int = 1;
    run_event("exc_vs_int", 0);
    ext_int = 1; timer_int = 1;
    run_event("ext_vs_timer", 0);

    // MRET.
    clear_inputs();
    mret_valid = 1; mstatus = 32'h80; mepc = 32'h344;
    run_event("mret", 0);

    // Redirect back-pressure for five cycles.
    clear_inputs();
    exc_valid = 1; exc_code = 4'd7; exc_epc = 32'h2000; mtvec = 32'h400; mstatus = 32'h8;
    run_event("stall5", 5);

    // Reset asserted in the middle of SAVE.
    clear_inputs();
    exc_valid = 1; exc_code = 4'd1; exc_epc = 32'h500; mtvec = 32'h600; mstatus = 32'h8;
    @(negedge CLK);
    check("rst_mid.ack", {31'b0, exc_ack}, 32'h1);
    tick();
    @(negedge CLK);
    check("rst_mid.in_save", {31'b0, mepc_rup}, 32'h1);
    RST = 1; exc_valid = 0;
    tick();
    @(negedge CLK);
    check("rst_mid.ctl", {29'b0, exc_ack, busy, redirect_valid}, 32'h0);
    check("rst_mid.pc", redirect_pc, 32'h0);
    check_quiet("rst_mid");
    tick();
    RST = 0;
    @(negedge CLK);
    check_quiet("rst_mid.after");
    check("rst_mid.after_busy", {31'b0, busy}, 32'h0);
    tick();

    // mip mirror.
    clear_inputs();
    timer_int = 1; mip = 32'h0;
    @(negedge CLK);
    check("mip.toggle_rup", {31'b0, mip_rup}, 32'h1);
    check("mip.toggle_next", mip_next, 32'h80);
    tick();
    mip = 32'h80;
    @(negedge CLK);
    check("mip.fed_back_rup", {31'b0, mip_rup}, 32'h0);
    tick();

    // Randomized events.
    for (int t = 0; t < 60; t++) begin
      exc_valid         = ($urandom_range(0, 3) == 0);
      mret_valid        = ($urandom_range(0, 3) == 0);
      exc_code          = 4'($urandom);
      exc_epc           = $urandom;
      exc_badaddr       = $urandom;
      exc_badaddr_valid = 1'($urandom);
      int_epc           = $urandom;
      ext_int           = 1'($urandom);
      soft_int          = 1'($urandom);
      timer_int         = 1'($urandom);
      mip               = $urandom;
      mie               = $urandom;
      mstatus           = $urandom;
      mtvec             = $urandom;
      mepc              = $urandom;
      run_event($sformatf("rand%0d", t), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
